// File: rtl/turf_udp_tx_arbiter_if.sv
// turf_udp_tx_arbiter_if: per-port UDP header/payload request streams
// plus the single shared header/payload path toward the UDP core.
interface turf_udp_tx_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS*64-1:0] s_udphdr_tdata;
    logic [NUM_PORTS*16-1:0] s_udphdr_tuser;
    logic [NUM_PORTS-1:0]    s_udphdr_tvalid;
    logic [NUM_PORTS-1:0]    s_udphdr_tready;
    logic [NUM_PORTS*64-1:0] s_udpdata_tdata;
    logic [NUM_PORTS*8-1:0]  s_udpdata_tkeep;
    logic [NUM_PORTS-1:0]    s_udpdata_tlast;
    logic [NUM_PORTS-1:0]    s_udpdata_tvalid;
    logic [NUM_PORTS-1:0]    s_udpdata_tready;
    logic [63:0]             m_udphdr_tdata;
    logic [15:0]             m_udphdr_tuser;
    logic                    m_udphdr_tvalid;
    logic                    m_udphdr_tready;
    logic [63:0]             m_udpdata_tdata;
    logic [7:0]              m_udpdata_tkeep;
    logic                    m_udpdata_tlast;
    logic                    m_udpdata_tvalid;
    logic                    m_udpdata_tready;

    // Arbiter side: consumes requests, drives the shared transmit path.
    modport master (
        input  s_udphdr_tdata, s_udphdr_tuser, s_udphdr_tvalid,
        output s_udphdr_tready,
        input  s_udpdata_tdata, s_udpdata_tkeep, s_udpdata_tlast,
        input  s_udpdata_tvalid,
        output s_udpdata_tready,
        output m_udphdr_tdata, m_udphdr_tuser, m_udphdr_tvalid,
        input  m_udphdr_tready,
        output m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast,
        output m_udpdata_tvalid,
        input  m_udpdata_tready
    );

    // Environment side: requesters and the downstream UDP core.
    modport slave (
        output s_udphdr_tdata, s_udphdr_tuser, s_udphdr_tvalid,
        input  s_udphdr_tready,
        output s_udpdata_tdata, s_udpdata_tkeep, s_udpdata_tlast,
        output s_udpdata_tvalid,
        input  s_udpdata_tready,
        input  m_udphdr_tdata, m_udphdr_tuser, m_udphdr_tvalid,
        output m_udphdr_tready,
        input  m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast,
        input  m_udpdata_tvalid,
        output m_udpdata_tready
    );
endinterface

// File: rtl/turf_udp_tx_arbiter.sv
// turf_udp_tx_arbiter: round-robin share of the UDP transmit path, one whole
// frame (header then payload through tlast) per grant.
// Optional: define UDP_ARB_LENGTH_CHECK_EN for the len_err beat-count check.
module turf_udp_tx_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    turf_udp_tx_arbiter_if.master bus,
    output logic [PORT_BITS-1:0] grant,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 len_err
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [PORT_BITS-1:0] grant_q;
    logic [PORT_BITS-1:0] last_q;
    logic [PORT_BITS-1:0] pick;
    logic [PORT_BITS-1:0] idx;
    logic                 found;
    logic                 any_req;
    logic                 hdr_hs;
    logic                 data_hs;
    logic                 fin;
    logic                 frame_done_q;

    assign any_req    = |bus.s_udphdr_tvalid;
    assign hdr_hs     = (state_q == S_HDR) && bus.m_udphdr_tvalid
                        && bus.m_udphdr_tready;
    assign data_hs    = (state_q == S_DATA) && bus.m_udpdata_tvalid
                        && bus.m_udpdata_tready;
    assign fin        = data_hs && bus.m_udpdata_tlast;
    assign grant      = grant_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

    // Round-robin search starting one past the last served port.
    always_comb begin
        pick  = last_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = PORT_BITS'((int'(last_q) + i) % NUM_PORTS);
            if (!found && bus.s_udphdr_tvalid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state: arbitrate, pass header, pass payload through tlast.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (any_req) state_d = S_HDR;
            S_HDR:   if (hdr_hs)  state_d = S_DATA;
            S_DATA:  if (fin)     state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output mux from the granted port; only the grantee sees ready.
    always_comb begin
        bus.s_udphdr_tready  = '0;
        bus.s_udpdata_tready = '0;
        bus.m_udphdr_tdata   = bus.s_udphdr_tdata[int'(grant_q)*64 +: 64];
        bus.m_udphdr_tuser   = bus.s_udphdr_tuser[int'(grant_q)*16 +: 16];
        bus.m_udpdata_tdata  = bus.s_udpdata_tdata[int'(grant_q)*64 +: 64];
        bus.m_udpdata_tkeep  = bus.s_udpdata_tkeep[int'(grant_q)*8 +: 8];
        bus.m_udpdata_tlast  = bus.s_udpdata_tlast[grant_q];
        bus.m_udphdr_tvalid  = 1'b0;
        bus.m_udpdata_tvalid = 1'b0;
        unique case (state_q)
            S_HDR: begin
                bus.m_udphdr_tvalid = bus.s_udphdr_tvalid[grant_q];
                bus.s_udphdr_tready[grant_q] = bus.m_udphdr_tready;
            end
            S_DATA: begin
                bus.m_udpdata_tvalid = bus.s_udpdata_tvalid[grant_q];
                bus.s_udpdata_tready[grant_q] = bus.m_udpdata_tready;
            end
            default: ;
        endcase
    end

    // State, grant, round-robin pointer and frame_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_q       <= PORT_BITS'(NUM_PORTS - 1);
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= fin;
            if (state_q == S_IDLE && any_req) grant_q <= pick;
            if (fin) last_q <= grant_q;
        end
    end

`ifdef UDP_ARB_LENGTH_CHECK_EN
    logic [12:0] beat_q;
    logic [15:0] len_q;
    logic [12:0] exp_beats;
    logic        len_err_q;

    // Beats implied by the UDP length field, never fewer than one.
    always_comb begin
        exp_beats = 13'd1;
        if (len_q > 16'd8) exp_beats = 13'((len_q - 16'd1) >> 3);
    end

    // Count payload beats and flag a mismatch on the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q    <= '0;
            len_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= fin && ((beat_q + 13'd1) != exp_beats);
            if (state_q == S_IDLE) beat_q <= '0;
            else if (data_hs) beat_q <= beat_q + 13'd1;
            if (hdr_hs) len_q <= bus.m_udphdr_tdata[15:0];
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif
endmodule

// File: tb/tb_turf_udp_tx_arbiter.sv
// tb_turf_udp_tx_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a frame-level round-robin model.
module tb_turf_udp_tx_arbiter;
    localparam int N = 4;
`ifdef UDP_ARB_LENGTH_CHECK_EN
    localparam bit LCHK = 1'b1;
`else
    localparam bit LCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       busy;
    logic       frame_done;
    logic       len_err;

    turf_udp_tx_arbiter_if #(.NUM_PORTS(N)) bus ();

    turf_udp_tx_arbiter #(.NUM_PORTS(N), .PORT_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .grant(grant),
        .busy(busy), .frame_done(frame_done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // source side
    bit [N-1:0]  en, pend, hsent, hv_cur, dv_cur;
    int          fid[N], nb[N], sbeat[N];
    logic [63:0] hdr_r[N];
    logic [15:0] user_r[N];
    int          nmin, nmax, hv_pct, dv_pct, hr_mode, dr_mode;
    logic        hr, dr;

    // frame-level model
    int m_phase, m_owner, m_grant, m_last, m_beat;
    bit m_done, m_lerr;
    int waits[N];

    // DUT-side observations for directed checks
    int dq[$];
    int beats_seen = 0;
    int fd_cnt = 0;

    function automatic logic [63:0] dat_of(int p, int f, int b);
        logic [31:0] lo;
        lo = 32'(b) * 32'h01010101 ^ 32'hA5A55A5A;
        return {8'(p), 24'(f), lo};
    endfunction

    function automatic logic [7:0] keep_of(int p, int f, int b);
        return 8'(p * 37 + f * 11 + b * 5) | 8'h01;
    endfunction

    function automatic int exp_beats(logic [15:0] len);
        if (len <= 16'd8) return 1;
        return (int'(len) - 8 + 7) / 8;
    endfunction

    function automatic logic next_rdy(int mode, logic cur);
        case (mode)
            0: return 1'($urandom_range(0, 1));
            1: return 1'b1;
            2: return !cur;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(string nm);
        tests++;
        fails++;
        $display("FAIL %s: timeout got none want event at %0t", nm, $time);
    endtask

    task automatic new_frame(int p);
        fid[p]++;
        nb[p]     = $urandom_range(nmin, nmax);
        hdr_r[p]  = {32'h0A000000 | 32'(p << 8) | 32'(fid[p] & 255),
                     16'(16'h1000 + p), 16'(8 + 8 * nb[p])};
        user_r[p] = 16'(16'hC000 + p);
        hsent[p]  = 1'b0;
        sbeat[p]  = 0;
        pend[p]   = en[p];
        hv_cur[p] = 1'b0;
        dv_cur[p] = 1'b0;
    endtask

    task automatic put(int p);
        bus.s_udphdr_tvalid[p]          = hv_cur[p];
        bus.s_udphdr_tdata[p*64 +: 64]  = hdr_r[p];
        bus.s_udphdr_tuser[p*16 +: 16]  = user_r[p];
        bus.s_udpdata_tvalid[p]         = dv_cur[p];
        bus.s_udpdata_tdata[p*64 +: 64] = dat_of(p, fid[p], sbeat[p]);
        bus.s_udpdata_tkeep[p*8 +: 8]   = keep_of(p, fid[p], sbeat[p]);
        bus.s_udpdata_tlast[p]          = (sbeat[p] == nb[p] - 1);
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (pend[p] && !hsent[p] && !hv_cur[p])
                hv_cur[p] = ($urandom_range(0, 99) < hv_pct);
            if (pend[p] && sbeat[p] < nb[p] && !dv_cur[p])
                dv_cur[p] = ($urandom_range(0, 99) < dv_pct);
            put(p);
        end
        hr = next_rdy(hr_mode, hr);
        dr = next_rdy(dr_mode, dr);
        bus.m_udphdr_tready  = hr;
        bus.m_udpdata_tready = dr;
    endtask

    // Compare DUT against the model, then advance the model one cycle.
    task automatic check();
        logic [N-1:0] ehr, edr;
        int o, w;
        ehr = '0;
        edr = '0;
        o   = m_owner;
        chk("busy", busy, m_phase != 0);
        chk("frame_done", frame_done, m_done);
        chk("grant", grant, m_grant);
        chk("len_err", len_err, LCHK & m_lerr);
        if (m_phase == 1) ehr[o] = hr;
        if (m_phase == 2) edr[o] = dr;
        chk("hdr_tready", bus.s_udphdr_tready, ehr);
        chk("data_tready", bus.s_udpdata_tready, edr);
        chk("hdr_tvalid", bus.m_udphdr_tvalid, m_phase == 1 && hv_cur[o]);
        chk("data_tvalid", bus.m_udpdata_tvalid, m_phase == 2 && dv_cur[o]);
        if (m_phase == 1 && hv_cur[o]) begin
            chk("hdr_tdata", bus.m_udphdr_tdata, hdr_r[o]);
            chk("hdr_tuser", bus.m_udphdr_tuser, user_r[o]);
        end
        if (m_phase == 2 && dv_cur[o]) begin
            chk("data_tdata", bus.m_udpdata_tdata, dat_of(o, fid[o], m_beat));
            chk("data_tkeep", bus.m_udpdata_tkeep, keep_of(o, fid[o], m_beat));
            chk("data_tlast", bus.m_udpdata_tlast, m_beat == nb[o] - 1);
        end
        if (bus.m_udphdr_tvalid && bus.m_udphdr_tready) dq.push_back(int'(grant));
        if (bus.m_udpdata_tvalid && bus.m_udpdata_tready) beats_seen++;
        if (frame_done) fd_cnt++;
        m_done = 1'b0;
        m_lerr = 1'b0;
        case (m_phase)
            0: if (|hv_cur) begin
                w = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && hv_cur[(m_last + k) % N]) w = (m_last + k) % N;
                for (int p = 0; p < N; p++)
                    if (p != w && hv_cur[p]) begin
                        waits[p]++;
                        chk("fairness", waits[p] < N, 1);
                    end
                waits[w] = 0;
                m_owner  = w;
                m_grant  = w;
                m_phase  = 1;
            end
            1: if (hv_cur[o] && hr) begin
                hv_cur[o] = 1'b0;
                hsent[o]  = 1'b1;
                m_phase   = 2;
                m_beat    = 0;
            end
            2: if (dv_cur[o] && dr) begin
                dv_cur[o] = 1'b0;
                sbeat[o]++;
                if (m_beat == nb[o] - 1) begin
                    m_done  = 1'b1;
                    m_lerr  = (m_beat + 1 != exp_beats(hdr_r[o][15:0]));
                    m_last  = o;
                    m_phase = 0;
                    new_frame(o);
                end else begin
                    m_beat++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        check();
    endtask

    task automatic set_cfg(bit [N-1:0] e, int mn, int mx, int hp, int dp,
                           int hm, int dm);
        en = e; nmin = mn; nmax = mx; hv_pct = hp; dv_pct = dp;
        hr_mode = hm; dr_mode = dm;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_phase = 0; m_owner = 0; m_grant = 0; m_last = N - 1; m_beat = 0;
        m_done  = 1'b0; m_lerr = 1'b0;
        for (int p = 0; p < N; p++) begin
            waits[p] = 0;
            new_frame(p);
            put(p);
        end
        hr = (hr_mode == 1);
        dr = (dr_mode == 1);
        bus.m_udphdr_tready  = hr;
        bus.m_udpdata_tready = dr;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_hvalid", bus.m_udphdr_tvalid, 0);
        chk("rst_dvalid", bus.m_udpdata_tvalid, 0);
        chk("rst_hready", bus.s_udphdr_tready, 0);
        chk("rst_dready", bus.s_udpdata_tready, 0);
        rst_n = 1'b1;
    endtask

    task automatic run_frames(string nm, int n, int budget);
        int start, c;
        start = fd_cnt;
        c = 0;
        while (fd_cnt - start < n && c < budget) begin
            cycle();
            c++;
        end
        if (fd_cnt - start < n) timeout(nm);
    endtask

    task automatic len_case(int len, int beats, bit exp);
        int c;
        set_cfg(4'b0001, beats, beats, 100, 100, 1, 1);
        do_reset();
        en[0] = 1'b0;
        hdr_r[0][15:0] = 16'(len);
        c = 0;
        while (!frame_done && c < 60) begin
            cycle();
            c++;
        end
        if (!frame_done) timeout("len_case");
        else chk($sformatf("len_err_%0d_%0d", len, beats), len_err, exp);
    endtask

    int t2_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        int b0, f0, c;
        bus.s_udphdr_tdata  = '0; bus.s_udphdr_tuser = '0;
        bus.s_udphdr_tvalid = '0; bus.s_udpdata_tdata = '0;
        bus.s_udpdata_tkeep = '0; bus.s_udpdata_tlast = '0;
        bus.s_udpdata_tvalid = '0;
        bus.m_udphdr_tready = 1'b0; bus.m_udpdata_tready = 1'b0;
        hr = 1'b0; dr = 1'b0;
        for (int p = 0; p < N; p++) fid[p] = 0;

        // single request on port 2, fixed header, 2 beats
        set_cfg(4'b0100, 2, 2, 100, 100, 1, 1);
        do_reset();
        en[2] = 1'b0;
        hdr_r[2] = 64'h0A000005_1234_0018;
        cycle();
        chk("t1_arb_busy", busy, 0);
        chk("t1_arb_hvalid", bus.m_udphdr_tvalid, 0);
        cycle();
        chk("t1_hvalid", bus.m_udphdr_tvalid, 1);
        chk("t1_hdata", bus.m_udphdr_tdata, 64'h0A000005_1234_0018);
        chk("t1_grant", grant, 2);
        repeat (3) cycle();
        chk("t1_done", frame_done, 1);
        chk("t1_busy_low", busy, 0);

        // all ports requesting continuously, 1-beat frames
        set_cfg(4'b1111, 1, 1, 100, 100, 1, 1);
        do_reset();
        dq.delete();
        run_frames("t2", 8, 200);
        chk("t2_count", dq.size() >= 8, 1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t2_grant%0d", i), i < dq.size() ? dq[i] : 99,
                t2_exp[i]);

        // payload ready toggling through 8-beat frames
        set_cfg(4'b1111, 8, 8, 100, 100, 1, 2);
        do_reset();
        b0 = beats_seen;
        f0 = fd_cnt;
        run_frames("t3", 3, 400);
        chk("t3_beats", beats_seen - b0, 24);

        // port 1 payload presented early, header stalled 5 cycles
        set_cfg(4'b0010, 2, 2, 100, 100, 3, 1);
        do_reset();
        en[1] = 1'b0;
        repeat (6) begin
            cycle();
            chk("t4_dready", bus.s_udpdata_tready[1], 0);
            chk("t4_dvalid_out", bus.m_udpdata_tvalid, 0);
        end
        hr_mode = 1;
        run_frames("t4", 1, 50);

        // reset asserted mid-payload
        set_cfg(4'b1111, 6, 6, 100, 100, 1, 1);
        do_reset();
        c = 0;
        while (!(m_phase == 2 && m_beat == 3) && c < 100) begin
            cycle();
            c++;
        end
        if (!(m_phase == 2 && m_beat == 3)) timeout("t5_reach");
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_hvalid", bus.m_udphdr_tvalid, 0);
        chk("t5_dvalid", bus.m_udpdata_tvalid, 0);
        chk("t5_hready", bus.s_udphdr_tready, 0);
        chk("t5_dready", bus.s_udpdata_tready, 0);
        do_reset();
        dq.delete();
        run_frames("t5", 1, 100);
        chk("t5_first", dq.size() > 0 ? dq[0] : 99, 0);

`ifdef UDP_ARB_LENGTH_CHECK_EN
        len_case(24, 3, 1'b1);
        len_case(24, 2, 1'b0);
        len_case(8, 1, 1'b0);
`endif

        // randomized traffic
        repeat (6) begin
            set_cfg(4'($urandom_range(1, 15)), 1, 8,
                    $urandom_range(30, 100), $urandom_range(30, 100),
                    $urandom_range(0, 2), $urandom_range(0, 2));
            do_reset();
            repeat (500) cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
